// File: rtl/data_compress_pkg.sv
// rtl/data_compress_pkg.sv - shared constants, width helpers and popcount for the lane compress/expand path
package data_compress_pkg;

    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_N  = 8;
    localparam int DEFAULT_CW = $clog2(DEFAULT_N) + 1;
    localparam int DEFAULT_BW = $clog2(2 * DEFAULT_N) + 1;

    // Lane count (0..N) and holding-buffer occupancy (0..2N) at the default lane count
    typedef logic [DEFAULT_CW-1:0] cnt_t;
    typedef logic [DEFAULT_BW-1:0] occ_t;

    // Width needed to hold a lane count 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Width needed to hold a buffer occupancy 0..2n
    function automatic int occ_width(input int n);
        return $clog2(2 * n) + 1;
    endfunction

    // Number of set bits in a default-width lane mask
    function automatic cnt_t popcount(input logic [DEFAULT_N-1:0] v);
        cnt_t s;
        s = '0;
        for (int i = 0; i < DEFAULT_N; i++) begin
            s = s + cnt_t'(v[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/lane_prefix_sum.sv
// rtl/lane_prefix_sum.sv - exclusive prefix count of a lane mask plus its total population
module lane_prefix_sum #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic [N-1:0]         mask,
    output logic [N-1:0][CW-1:0] idx,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    // idx[k] counts set mask bits strictly below lane k; total is the full count
    always_comb begin
        acc = '0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx[k] = acc;
            acc    = acc + CW'(mask[k]);
        end
        total = acc;
    end

endmodule

// File: rtl/data_expand.sv
// rtl/data_expand.sv - scatter densely packed lanes onto the positions selected by a per-beat mask
import data_compress_pkg::*;

module data_expand #(
    parameter int DW = DEFAULT_DW,
    parameter int N  = DEFAULT_N,
    parameter int CW = cnt_width(N),
    parameter int BW = occ_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0][DW-1:0] i_data,
    input  logic [CW-1:0]        i_cnt,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [N-1:0]         m_mask,
    input  logic                 m_valid,
    output logic                 m_ready,
    output logic [N-1:0][DW-1:0] o_data,
    output logic [N-1:0]         o_lane_valid,
    output logic                 o_valid,
    input  logic                 o_ready
);

    localparam int DEPTH = 2 * N;
    localparam int LW    = $clog2(N);

    // Holding buffer: lane 0 is always the oldest unconsumed lane
    logic [DW-1:0]         hold_buf [DEPTH];
    logic [DW-1:0]         buf_next [DEPTH];
    logic [BW-1:0]         cnt;
    logic [BW-1:0]         cnt_next;

    logic [N-1:0][CW-1:0]  idx;
    logic [CW-1:0]         pop;
    logic [BW-1:0]         pop_used;
    logic [BW-1:0]         in_add;
    logic [BW-1:0]         base;
    logic [BW-1:0]         src;
    logic [BW-1:0]         dst;
    logic [BW-1:0]         off;
    logic                  fire_i;
    logic                  fire_m;
    logic [N-1:0][DW-1:0]  expand;

    lane_prefix_sum #(
        .N  (N),
        .CW (CW)
    ) u_prefix (
        .mask  (m_mask),
        .idx   (idx),
        .total (pop)
    );

    // Handshakes look only at registered occupancy, so a mask can never use lanes arriving this cycle
    always_comb begin
        i_ready = ~rst & (cnt <= BW'(N));
        m_ready = ~rst & m_valid & (cnt >= BW'(pop)) & (~o_valid | o_ready);
        fire_i  = i_valid & i_ready;
        fire_m  = m_ready;
    end

    // Scatter the oldest pop buffered lanes onto the set mask positions
    always_comb begin
        expand = '0;
        for (int k = 0; k < N; k++) begin
            if (m_mask[k]) begin
                expand[k] = hold_buf[idx[k]];
            end
        end
    end

    // Next buffer: drop consumed lanes from the front, then append new lanes behind the survivors
    always_comb begin
        pop_used = fire_m ? BW'(pop) : '0;
        in_add   = fire_i ? BW'(i_cnt) : '0;
        base     = cnt - pop_used;
        cnt_next = base + in_add;
        src      = '0;
        dst      = '0;
        off      = '0;
        for (int j = 0; j < DEPTH; j++) begin
            buf_next[j] = hold_buf[j];
        end
        for (int j = 0; j < DEPTH; j++) begin
            src = BW'(j) + pop_used;
            if (fire_m && (src < BW'(DEPTH))) begin
                buf_next[j] = hold_buf[src[BW-2:0]];
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            dst = BW'(j);
            off = dst - base;
            if (fire_i && (dst >= base) && (off < in_add)) begin
                buf_next[j] = i_data[off[LW-1:0]];
            end
        end
    end

    // Occupancy register; reset discards any residual lanes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Buffer contents need no reset because occupancy alone defines which lanes are live
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            hold_buf[j] <= buf_next[j];
        end
    end

    // Output beat register: load on mask fire, clear valid when taken, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data       <= '0;
            o_lane_valid <= '0;
            o_valid      <= 1'b0;
        end else if (fire_m) begin
            o_data       <= expand;
            o_lane_valid <= m_mask;
            o_valid      <= 1'b1;
        end else if (o_valid && o_ready) begin
            o_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_expand.sv
// tb/tb_data_expand.sv - directed self-checking bench for data_expand
module tb_data_expand;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int CW = 4;
    localparam int BW = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0][DW-1:0] i_data;
    logic [CW-1:0]        i_cnt;
    logic                 i_valid;
    logic                 i_ready;
    logic [N-1:0]         m_mask;
    logic                 m_valid;
    logic                 m_ready;
    logic [N-1:0][DW-1:0] o_data;
    logic [N-1:0]         o_lane_valid;
    logic                 o_valid;
    logic                 o_ready;

    int total = 0;
    int bad   = 0;
    logic [N-1:0][DW-1:0] exp_d;

    data_expand #(
        .DW (DW),
        .N  (N),
        .CW (CW),
        .BW (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_cnt        (i_cnt),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .m_mask       (m_mask),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .o_data       (o_data),
        .o_lane_valid (o_lane_valid),
        .o_valid      (o_valid),
        .o_ready      (o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [N-1:0] lv);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_lane%0d", tag, k), 64'(o_data[k]), 64'(exp_d[k]));
        end
        chk($sformatf("%s_lane_valid", tag), 64'(o_lane_valid), 64'(lv));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Meaningful lanes get base+k; the rest carry junk that must never reach the output
    task automatic load_in(input int n, input logic [DW-1:0] base);
        i_cnt = CW'(n);
        for (int k = 0; k < N; k++) begin
            if (k < n) i_data[k] = base + DW'(k);
            else       i_data[k] = 32'hDEAD_0000 | DW'(k);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && i_valid === 1'b1) begin
            assert (i_cnt <= CW'(N)) else begin
                bad++;
                $error("FAIL illegal_i_cnt observed=%0d expected<=%0d", i_cnt, N);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both inputs valid
        rst = 1'b1; i_valid = 1'b1; i_data = '0; i_cnt = 4'd1;
        m_valid = 1'b1; m_mask = 8'hFF; o_ready = 1'b1;
        #1;
        chk("rst_i_ready_pre", 64'(i_ready), 0);
        chk("rst_m_ready_pre", 64'(m_ready), 0);
        tick();
        tick();
        chk("rst_o_valid", 64'(o_valid), 0);
        chk("rst_lane_valid", 64'(o_lane_valid), 0);
        chk("rst_o_data", 64'(|o_data), 0);
        chk("rst_cnt", 64'(dut.cnt), 0);
        chk("rst_i_ready", 64'(i_ready), 0);
        chk("rst_m_ready", 64'(m_ready), 0);
        rst = 1'b0; i_valid = 1'b0;
        #1;
        chk("post_rst_i_ready", 64'(i_ready), 1);
        chk("post_rst_m_ready", 64'(m_ready), 0);

        // Basic scatter of three lanes onto mask A4
        m_valid = 1'b0;
        load_in(3, 32'h1000_0000); i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("t2_cnt_in", 64'(dut.cnt), 3);
        m_mask = 8'hA4; m_valid = 1'b1;
        #1;
        chk("t2_m_ready", 64'(m_ready), 1);
        tick();
        m_valid = 1'b0;
        exp_d = '0;
        exp_d[2] = 32'h1000_0000; exp_d[5] = 32'h1000_0001; exp_d[7] = 32'h1000_0002;
        chk_beat("t2", 8'hA4);
        chk("t2_o_valid", 64'(o_valid), 1);
        chk("t2_cnt", 64'(dut.cnt), 0);

        // Cross-beat accumulation: 5 + 4 lanes feed a full mask
        load_in(5, 32'h2000_0000); i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("t3_o_valid_drop", 64'(o_valid), 0);
        m_mask = 8'hFF; m_valid = 1'b1;
        #1;
        chk("t3_m_ready_wait", 64'(m_ready), 0);
        load_in(4, 32'h2100_0000); i_valid = 1'b1;
        #1;
        chk("t3_i_ready", 64'(i_ready), 1);
        chk("t3_m_ready_no_bypass", 64'(m_ready), 0);
        tick();
        i_valid = 1'b0;
        #1;
        chk("t3_m_ready", 64'(m_ready), 1);
        chk("t3_cnt_9", 64'(dut.cnt), 9);
        tick();
        m_valid = 1'b0; o_ready = 1'b0;
        for (int k = 0; k < 5; k++) exp_d[k] = 32'h2000_0000 + DW'(k);
        for (int k = 5; k < 8; k++) exp_d[k] = 32'h2100_0000 + DW'(k - 5);
        chk_beat("t3", 8'hFF);
        chk("t3_cnt_res", 64'(dut.cnt), 1);

        // Backpressure: output held, mask pending, inputs fill to 12
        m_mask = 8'h03; m_valid = 1'b1;
        load_in(3, 32'h3000_0000); i_valid = 1'b1;
        #1;
        chk("t4_i_ready_a", 64'(i_ready), 1);
        tick();
        chk("t4_cnt_4", 64'(dut.cnt), 4);
        chk_beat("t4_hold_a", 8'hFF);
        chk("t4_m_ready_bp", 64'(m_ready), 0);
        load_in(4, 32'h3100_0000);
        #1;
        chk("t4_i_ready_b", 64'(i_ready), 1);
        tick();
        chk("t4_cnt_8", 64'(dut.cnt), 8);
        chk("t4_i_ready_at8", 64'(i_ready), 1);
        chk("t4_m_ready_bp8", 64'(m_ready), 0);
        load_in(4, 32'h3200_0000);
        tick();
        chk("t4_cnt_12", 64'(dut.cnt), 12);
        chk("t4_i_ready_at12", 64'(i_ready), 0);
        load_in(4, 32'h3300_0000);
        tick();
        chk("t4_cnt_12_hold", 64'(dut.cnt), 12);
        chk_beat("t4_hold_b", 8'hFF);
        chk("t4_o_valid_hold", 64'(o_valid), 1);
        chk("t4_m_ready_bp12", 64'(m_ready), 0);
        o_ready = 1'b1;
        #1;
        chk("t4_m_ready_release", 64'(m_ready), 1);
        chk("t4_i_ready_full", 64'(i_ready), 0);
        tick();
        i_valid = 1'b0; m_valid = 1'b0;
        exp_d = '0;
        exp_d[0] = 32'h2100_0003; exp_d[1] = 32'h3000_0000;
        chk_beat("t4_out", 8'h03);
        chk("t4_o_valid_stays", 64'(o_valid), 1);
        chk("t4_cnt_10", 64'(dut.cnt), 10);

        // Ordering across beat boundaries, then zero mask and zero count
        m_mask = 8'hFF; m_valid = 1'b1;
        #1;
        chk("t5_m_ready_drain", 64'(m_ready), 1);
        tick();
        exp_d[0] = 32'h3000_0001; exp_d[1] = 32'h3000_0002;
        for (int k = 0; k < 4; k++) exp_d[2 + k] = 32'h3100_0000 + DW'(k);
        exp_d[6] = 32'h3200_0000; exp_d[7] = 32'h3200_0001;
        chk_beat("t5_order", 8'hFF);
        chk("t5_cnt_2", 64'(dut.cnt), 2);
        m_mask = 8'h00;
        #1;
        chk("t5_m_ready_zero", 64'(m_ready), 1);
        tick();
        m_valid = 1'b0;
        exp_d = '0;
        chk_beat("t5_zero", 8'h00);
        chk("t5_zero_o_valid", 64'(o_valid), 1);
        chk("t5_zero_cnt", 64'(dut.cnt), 2);
        load_in(0, 32'h0); i_valid = 1'b1;
        #1;
        chk("t5_i_ready_icnt0", 64'(i_ready), 1);
        tick();
        i_valid = 1'b0;
        chk("t5_icnt0_cnt", 64'(dut.cnt), 2);
        chk("t5_o_valid_taken", 64'(o_valid), 0);

        // Reset mid-operation discards buffered lanes and the pending beat
        o_ready = 1'b0;
        m_mask = 8'h00; m_valid = 1'b1;
        load_in(4, 32'h4000_0000); i_valid = 1'b1;
        tick();
        i_valid = 1'b0; m_valid = 1'b0;
        chk("t6_cnt_6", 64'(dut.cnt), 6);
        chk("t6_o_valid_pre", 64'(o_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_cnt", 64'(dut.cnt), 0);
        chk("t6_rst_o_valid", 64'(o_valid), 0);
        chk("t6_rst_lane_valid", 64'(o_lane_valid), 0);
        chk("t6_rst_o_data", 64'(|o_data), 0);
        o_ready = 1'b1;
        load_in(1, 32'h5000_0000); i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        m_mask = 8'h01; m_valid = 1'b1;
        #1;
        chk("t6_m_ready", 64'(m_ready), 1);
        tick();
        m_valid = 1'b0;
        exp_d = '0;
        exp_d[0] = 32'h5000_0000;
        chk_beat("t6_x", 8'h01);
        chk("t6_cnt_end", 64'(dut.cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
